mti_cpi_scheduler: RTL

Sequences one coherent processing interval (CPI) through the MTI canceller and pulse-accumulation datapath. It is armed by a start pulse and paced by the transmitter's PRF sync. For each pulse it drives the record window, range-bin and pulse indices, and the canceller enable. After the last pulse it runs one accumulation sweep over all range bins, then signals done. It sits between the waveform/timing generator and the MTI/accumulator datapath.

---
 rtl/mti_ctrl_pkg.sv | 21 ++
 rtl/mti_bin_counter.sv | 34 +++
 rtl/mti_cpi_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mti_ctrl_pkg.sv
// MTI CPI scheduler shared types and defaults.
// FSM state enum, default geometry, canceller start depth.
package mti_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    RECORD,
    ACC,
    DONE
  } state_e;

  localparam int unsigned DEF_N_RANGE = 512;
  localparam int unsigned DEF_N_PULSE = 16;
  localparam int unsigned DEF_TIMEOUT = 4096;

  // First pulse index at which the
  // canceller output is valid.
  localparam int unsigned MTI_START_DEPTH = 2;

endpackage

// File: rtl/mti_bin_counter.sv
// Counter 0..N-1 with clear-to-zero, enable, terminal flag.
// clr_i wins over en_i; wraps to 0 after N-1 when enabled.
module mti_bin_counter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == W'(N - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mti_cpi_scheduler.sv
// Sequences one CPI: wait PRF sync, record, accumulate, done.
// In: start/abort/prf_sync. Out: record/acc strobes, indices, status.
module mti_cpi_scheduler
  import mti_ctrl_pkg::*;
#(
  parameter int unsigned N_RANGE = DEF_N_RANGE,
  parameter int unsigned N_PULSE = DEF_N_PULSE,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned RW      = $clog2(N_RANGE),
  parameter int unsigned PW      = $clog2(N_PULSE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          prf_sync,
  output logic          rec_flag,
  output logic [RW-1:0] range_idx,
  output logic [PW-1:0] pulse_idx,
  output logic          mti_en,
  output logic          acc_en,
  output logic [RW-1:0] acc_bin,
  output logic          busy,
  output logic          done,
  output logic          sync_miss,
  output logic          timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_e        state_q, state_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          miss_q, miss_d;
  logic          to_q, to_d;

  logic [RW-1:0] bin_cnt;
  logic          bin_tc;
  logic          bin_run;
  logic [TW-1:0] unused_wait_cnt;
  logic          wait_tc;
  logic          in_wait;
  logic          pulse_last;

  assign bin_run    = (state_q == RECORD) ||
                      (state_q == ACC);
  assign in_wait    = (state_q == WAIT_SYNC);
  assign pulse_last = (pulse_q == PW'(N_PULSE - 1));

  // One counter serves both the record
  // window and the accumulation sweep;
  // it wraps to 0 between them.
  mti_bin_counter #(
    .N (N_RANGE),
    .W (RW)
  ) u_bin_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (abort | ~bin_run),
    .en_i  (bin_run),
    .cnt_o (bin_cnt),
    .tc_o  (bin_tc)
  );

  mti_bin_counter #(
    .N (TIMEOUT),
    .W (TW)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (abort | ~in_wait | prf_sync),
    .en_i  (in_wait),
    .cnt_o (unused_wait_cnt),
    .tc_o  (wait_tc)
  );

  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    miss_d  = miss_q;
    to_d    = to_q;
    if (abort) begin
      // Sticky flags survive an abort.
      if (state_q != IDLE) begin
        state_d = IDLE;
        pulse_d = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = WAIT_SYNC;
            pulse_d = '0;
            miss_d  = 1'b0;
            to_d    = 1'b0;
          end
        end
        WAIT_SYNC: begin
          // Sync beats a coincident timeout.
          if (prf_sync) begin
            state_d = RECORD;
          end else if (wait_tc) begin
            state_d = IDLE;
            pulse_d = '0;
            to_d    = 1'b1;
          end
        end
        RECORD: begin
          if (prf_sync) miss_d = 1'b1;
          if (bin_tc) begin
            if (pulse_last) begin
              state_d = ACC;
            end else begin
              state_d = WAIT_SYNC;
              pulse_d = pulse_q + PW'(1);
            end
          end
        end
        ACC: begin
          if (bin_tc) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
          pulse_d = '0;
        end
        default: begin
          state_d = IDLE;
          pulse_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pulse_q <= '0;
      miss_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      miss_q  <= miss_d;
      to_q    <= to_d;
    end
  end

  assign rec_flag    = (state_q == RECORD);
  assign acc_en      = (state_q == ACC);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign range_idx   = rec_flag ? bin_cnt : '0;
  assign acc_bin     = acc_en ? bin_cnt : '0;
  assign pulse_idx   = pulse_q;
  assign mti_en      = rec_flag &&
                       (pulse_q >= PW'(MTI_START_DEPTH));
  assign sync_miss   = miss_q;
  assign timeout_err = to_q;

endmodule
